// File: rtl/caesar_pkg.sv
// caesar_pkg: shared constants and FSM state type for the Caesar decryptor
package caesar_pkg;
    localparam int ALPHA_LEN = 26;
    localparam int LETTER_W = 5;
    localparam logic [4:0] ERR_LETTER = 5'd31;
    localparam logic [3:0] ERR_BCD = 4'hF;
    typedef enum logic [2:0] {IDLE, CALC, CONV1, CONV2, HOLD} dec_state_t;
endpackage

// File: rtl/caesar_key_sweep.sv
// caesar_key_sweep: mod-ALPHA key counter advanced by tick while enabled
module caesar_key_sweep #(
    parameter int ALPHA = 26,
    parameter int LW = 5
) (
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic          tick,
    input  logic          en,
    output logic [LW-1:0] count
);
    localparam logic [LW-1:0] LAST = LW'(ALPHA - 1);
    // advance on each enabled tick, wrapping after the last letter
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) count <= '0;
        else if (tick && en) count <= (count == LAST) ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/caesar_decrypt.sv
// caesar_decrypt: streaming Caesar decryptor with BCD output; CAESAR_SWEEP_EN adds a tick-driven key sweep
module caesar_decrypt
    import caesar_pkg::*;
#(
    parameter int ALPHA = 26,
    parameter int LW = 5
) (
    input  logic          CLOCK_50,
    input  logic          rst,
    input  logic          tick,
    input  logic [LW-1:0] key,
    input  logic          in_valid,
    input  logic [LW-1:0] in_letter,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] out_letter,
    output logic [3:0]    out_tens,
    output logic [3:0]    out_ones,
    output logic          out_err
`ifdef CAESAR_SWEEP_EN
    ,
    input  logic          sweep_en,
    output logic [LW-1:0] sweep_key
`endif
);
    localparam logic [LW-1:0] A_L = LW'(ALPHA);
    localparam logic [LW:0] A_W = (LW+1)'(ALPHA);
    localparam logic [LW-1:0] TEN = LW'(10);
    dec_state_t state, state_n;
    logic [LW-1:0] let_r, key_r, d_r, rem, rem_n, eff_key;
    logic [LW:0] d_raw, d_mod;
    logic [3:0] tens, tens_n;
    logic err_r, bad;
`ifdef CAESAR_SWEEP_EN
    caesar_key_sweep #(.ALPHA(ALPHA), .LW(LW)) u_sweep (
        .CLOCK_50(CLOCK_50),
        .rst(rst),
        .tick(tick),
        .en(sweep_en),
        .count(sweep_key)
    );
    assign eff_key = sweep_en ? sweep_key : key;
`else
    logic unused_tick;
    assign unused_tick = tick;
    assign eff_key = key;
`endif
    assign in_ready = (state == IDLE);
    assign bad = (let_r >= A_L) || (key_r >= A_L);
    assign d_raw = {1'b0, let_r} + A_W - {1'b0, key_r};
    assign d_mod = (d_raw >= A_W) ? d_raw - A_W : d_raw;
    assign rem_n = (rem >= TEN) ? rem - TEN : rem;
    assign tens_n = tens + {3'b0, rem >= TEN};
    // state register
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // next-state sequencing: fixed three-cycle compute, then hold until consumed
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? CALC : IDLE;
            CALC:    state_n = CONV1;
            CONV1:   state_n = CONV2;
            CONV2:   state_n = HOLD;
            HOLD:    state_n = out_ready ? IDLE : HOLD;
            default: state_n = IDLE;
        endcase
    end
    // datapath: latch input, subtract key mod ALPHA, two BCD steps, register outputs
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            let_r <= '0;
            key_r <= '0;
            d_r <= '0;
            rem <= '0;
            tens <= '0;
            err_r <= 1'b0;
            out_valid <= 1'b0;
            out_err <= 1'b0;
            out_letter <= '0;
            out_tens <= '0;
            out_ones <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    let_r <= in_letter;
                    key_r <= eff_key;
                end
                CALC: begin
                    err_r <= bad;
                    d_r <= d_mod[LW-1:0];
                    rem <= d_mod[LW-1:0];
                    tens <= '0;
                end
                CONV1: begin
                    rem <= rem_n;
                    tens <= tens_n;
                end
                CONV2: begin
                    out_valid <= 1'b1;
                    out_err <= err_r;
                    out_letter <= err_r ? ERR_LETTER : d_r;
                    out_tens <= err_r ? ERR_BCD : tens_n;
                    out_ones <= err_r ? ERR_BCD : rem_n[3:0];
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_caesar_decrypt.sv
// tb_caesar_decrypt: directed self-checking bench for caesar_decrypt
module tb_caesar_decrypt;
    logic CLOCK_50 = 0;
    logic rst = 1;
    logic tick = 0;
    logic [4:0] key = 0;
    logic in_valid = 0;
    logic [4:0] in_letter = 0;
    logic in_ready;
    logic out_valid;
    logic out_ready = 1;
    logic [4:0] out_letter;
    logic [3:0] out_tens, out_ones;
    logic out_err;
`ifdef CAESAR_SWEEP_EN
    logic sweep_en = 0;
    logic [4:0] sweep_key;
`endif
    int total = 0;
    int passed = 0;

    caesar_decrypt dut (
        .CLOCK_50(CLOCK_50),
        .rst(rst),
        .tick(tick),
        .key(key),
        .in_valid(in_valid),
        .in_letter(in_letter),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_letter(out_letter),
        .out_tens(out_tens),
        .out_ones(out_ones),
        .out_err(out_err)
`ifdef CAESAR_SWEEP_EN
        ,
        .sweep_en(sweep_en),
        .sweep_key(sweep_key)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send(input logic [4:0] l, input logic [4:0] k);
        in_valid = 1;
        in_letter = l;
        key = k;
        step();
        in_valid = 0;
    endtask

    task automatic test_reset_values();
        #5;
        total++;
        if ({in_ready, out_valid, out_err, out_letter, out_tens, out_ones} !== {1'b1, 1'b1 ^ 1'b1, 1'b0, 5'd0, 4'd0, 4'd0})
            $display("FAIL reset_values got rdy=%0b v=%0b e=%0b l=%0d t=%0d o=%0d exp 1 0 0 0 0 0",
                     in_ready, out_valid, out_err, out_letter, out_tens, out_ones);
        else passed++;
        step();
        rst = 0;
        step();
    endtask

    task automatic test_basic();
        send(5'd3, 5'd3);
        step();
        step();
        total++;
        if (out_valid !== 1'b0) $display("FAIL basic_latency_early got out_valid=%0b exp 0", out_valid);
        else passed++;
        step();
        total++;
        if (out_valid !== 1'b1) $display("FAIL basic_latency got out_valid=%0b exp 1", out_valid);
        else passed++;
        total++;
        if ({out_letter, out_tens, out_ones, out_err} !== {5'd0, 4'd0, 4'd0, 1'b0})
            $display("FAIL basic_value got l=%0d t=%0d o=%0d e=%0b exp 0 0 0 0", out_letter, out_tens, out_ones, out_err);
        else passed++;
        step();
        total++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL basic_release got v=%0b rdy=%0b exp 0 1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_wrap();
        send(5'd1, 5'd5);
        repeat (3) step();
        total++;
        if ({out_valid, out_letter, out_tens, out_ones} !== {1'b1, 5'd22, 4'd2, 4'd2})
            $display("FAIL wrap_1_5 got v=%0b l=%0d t=%0d o=%0d exp 1 22 2 2", out_valid, out_letter, out_tens, out_ones);
        else passed++;
        step();
        send(5'd25, 5'd0);
        repeat (3) step();
        total++;
        if ({out_valid, out_letter, out_tens, out_ones} !== {1'b1, 5'd25, 4'd2, 4'd5})
            $display("FAIL wrap_25_0 got v=%0b l=%0d t=%0d o=%0d exp 1 25 2 5", out_valid, out_letter, out_tens, out_ones);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        int bad_cycles = 0;
        send(5'd4, 5'd1);
        step();
        rst = 1;
        #1;
        total++;
        if ({in_ready, out_valid, out_err, out_letter, out_tens, out_ones} !== {1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0})
            $display("FAIL reset_mid got rdy=%0b v=%0b e=%0b l=%0d t=%0d o=%0d exp 1 0 0 0 0 0",
                     in_ready, out_valid, out_err, out_letter, out_tens, out_ones);
        else passed++;
        step();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad_cycles++;
        end
        total++;
        if (bad_cycles != 0) $display("FAIL reset_no_pulse got %0d bad cycles exp 0", bad_cycles);
        else passed++;
    endtask

    task automatic test_backpressure();
        int bad_cycles = 0;
        out_ready = 0;
        send(5'd7, 5'd2);
        in_valid = 1;
        in_letter = 5'd9;
        repeat (3) step();
        total++;
        if ({out_valid, out_letter, out_tens, out_ones} !== {1'b1, 5'd5, 4'd0, 4'd5})
            $display("FAIL bp_value got v=%0b l=%0d t=%0d o=%0d exp 1 5 0 5", out_valid, out_letter, out_tens, out_ones);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            step();
            if ({out_valid, in_ready, out_letter, out_tens, out_ones} !== {1'b1, 1'b0, 5'd5, 4'd0, 4'd5}) bad_cycles++;
        end
        total++;
        if (bad_cycles != 0) $display("FAIL bp_stable got %0d bad cycles exp 0", bad_cycles);
        else passed++;
        out_ready = 1;
        step();
        total++;
        if ({out_valid, in_ready, out_letter} !== {1'b0, 1'b1, 5'd5})
            $display("FAIL bp_release got v=%0b rdy=%0b l=%0d exp 0 1 5", out_valid, in_ready, out_letter);
        else passed++;
        step();
        in_valid = 0;
        total++;
        if (in_ready !== 1'b0) $display("FAIL bp_next_accept got rdy=%0b exp 0", in_ready);
        else passed++;
        repeat (3) step();
        total++;
        if ({out_valid, out_letter, out_tens, out_ones} !== {1'b1, 5'd7, 4'd0, 4'd7})
            $display("FAIL bp_next_value got v=%0b l=%0d t=%0d o=%0d exp 1 7 0 7", out_valid, out_letter, out_tens, out_ones);
        else passed++;
        step();
    endtask

    task automatic test_error();
        send(5'd27, 5'd2);
        repeat (3) step();
        total++;
        if ({out_valid, out_err, out_letter, out_tens, out_ones} !== {1'b1, 1'b1, 5'd31, 4'hF, 4'hF})
            $display("FAIL err_letter got v=%0b e=%0b l=%0d t=%0h o=%0h exp 1 1 31 f f", out_valid, out_err, out_letter, out_tens, out_ones);
        else passed++;
        step();
        total++;
        if ({out_valid, out_err, out_letter} !== {1'b0, 1'b0, 5'd31})
            $display("FAIL err_clear got v=%0b e=%0b l=%0d exp 0 0 31", out_valid, out_err, out_letter);
        else passed++;
        send(5'd0, 5'd26);
        repeat (3) step();
        total++;
        if ({out_valid, out_err, out_letter, out_tens, out_ones} !== {1'b1, 1'b1, 5'd31, 4'hF, 4'hF})
            $display("FAIL err_key got v=%0b e=%0b l=%0d t=%0h o=%0h exp 1 1 31 f f", out_valid, out_err, out_letter, out_tens, out_ones);
        else passed++;
        step();
        send(5'd12, 5'd0);
        repeat (3) step();
        total++;
        if ({out_err, out_letter, out_tens, out_ones} !== {1'b0, 5'd12, 4'd1, 4'd2})
            $display("FAIL err_recover got e=%0b l=%0d t=%0d o=%0d exp 0 12 1 2", out_err, out_letter, out_tens, out_ones);
        else passed++;
        step();
    endtask

`ifdef CAESAR_SWEEP_EN
    task automatic test_sweep();
        int bad_cycles = 0;
        sweep_en = 1;
        key = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (sweep_key !== 5'(i)) bad_cycles++;
            tick = 1;
            step();
            tick = 0;
        end
        total++;
        if (bad_cycles != 0) $display("FAIL sweep_seq got %0d bad steps exp 0", bad_cycles);
        else passed++;
        total++;
        if (sweep_key !== 5'd0) $display("FAIL sweep_wrap got %0d exp 0", sweep_key);
        else passed++;
        repeat (4) begin
            tick = 1;
            step();
        end
        tick = 1;
        key = 5'd20;
        send(5'd10, 5'd20);
        tick = 0;
        total++;
        if (sweep_key !== 5'd5) $display("FAIL sweep_incr got %0d exp 5", sweep_key);
        else passed++;
        repeat (3) step();
        total++;
        if ({out_valid, out_letter} !== {1'b1, 5'd6}) $display("FAIL sweep_key_latch got v=%0b l=%0d exp 1 6", out_valid, out_letter);
        else passed++;
        step();
        sweep_en = 0;
        tick = 1;
        step();
        tick = 0;
        total++;
        if (sweep_key !== 5'd5) $display("FAIL sweep_hold got %0d exp 5", sweep_key);
        else passed++;
    endtask
`endif

    initial begin
        test_reset_values();
        test_basic();
        test_wrap();
        test_reset_mid();
        test_backpressure();
        test_error();
`ifdef CAESAR_SWEEP_EN
        test_sweep();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
